// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: widths, opcodes and fetch FSM states.
package cpu_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StExec,
      StHalt
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with sync clear, hold, +1, +2 and load; arithmetic wraps modulo 2^ADDR_W.
module fetch_pc #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_inc2,
   input  logic              i_inc1,
   input  logic [ADDR_W-1:0] i_load_val,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // PC register: clear beats load beats +2 beats +1; otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= '0;
      end else if (i_clear) begin
         r_pc <= '0;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc2) begin
         r_pc <= r_pc + ADDR_W'(2);
      end else if (i_inc1) begin
         r_pc <= r_pc + ADDR_W'(1);
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage: fetch FSM, instruction register, PC control and the
// memory port mux between the program-load path and the PC.
module instr_fetch #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_in,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              acc_zero,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        opcode,
   output logic [ADDR_W-1:0] operand_addr,
   output logic              instr_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   import cpu_pkg::*;

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic [DATA_W-1:0] r_ir;
   logic [2:0]        w_ir_op;
   logic              w_load;
   logic              w_pc_clear;
   logic              w_pc_load;
   logic              w_pc_inc1;
   logic              w_pc_inc2;

   // Reset outranks the load path, so gate it to keep every output at its reset value.
   assign w_load  = load_in & ~reset;
   assign w_ir_op = r_ir[DATA_W-1 -: 3];

   fetch_pc #(
      .ADDR_W (ADDR_W)
   ) u_fetch_pc (
      .clock      (clock),
      .reset      (reset),
      .i_clear    (w_pc_clear),
      .i_load     (w_pc_load),
      .i_inc2     (w_pc_inc2),
      .i_inc1     (w_pc_inc1),
      .i_load_val (r_ir[ADDR_W-1:0]),
      .o_pc       (pc)
   );

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Instruction register: captured in LATCH, discarded whenever load mode is active.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ir <= '0;
      end else if (load_in) begin
         r_ir <= '0;
      end else if (r_state == StLatch) begin
         r_ir <= mem_rdata;
      end
   end

   // Next state and PC control; load mode overrides everything, including the EXEC update.
   always_comb begin
      w_state_next = r_state;
      w_pc_clear   = 1'b0;
      w_pc_load    = 1'b0;
      w_pc_inc1    = 1'b0;
      w_pc_inc2    = 1'b0;
      if (load_in) begin
         w_state_next = StIdle;
         w_pc_clear   = 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_next = StFetch;
               w_pc_clear   = 1'b1;
            end
            StFetch: w_state_next = StLatch;
            StLatch: w_state_next = StExec;
            StExec: begin
               w_state_next = (w_ir_op == OP_HLT) ? StHalt : StFetch;
               if (w_ir_op == OP_JMP) begin
                  w_pc_load = 1'b1;
               end else if ((w_ir_op == OP_SKZ) && acc_zero) begin
                  w_pc_inc2 = 1'b1;
               end else begin
                  w_pc_inc1 = 1'b1;
               end
            end
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StIdle;
         endcase
      end
   end

   assign mem_addr     = w_load ? load_addr : pc;
   assign mem_we       = w_load & load_we;
   assign mem_wdata    = w_load ? load_data : '0;
   assign mem_rd       = ~w_load & (r_state == StFetch);
   assign instr_valid  = (r_state == StExec);
   assign opcode       = instr_valid ? w_ir_op : OP_HLT;
   assign operand_addr = r_ir[ADDR_W-1:0];
   assign halted       = (r_state == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, instruction scoreboard, vector table
// and hand-written multi-cycle sequences.
module tb_instr_fetch;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       load_in = 1'b0;
   logic       load_we = 1'b0;
   logic [4:0] load_addr = '0;
   logic [7:0] load_data = '0;
   logic [7:0] mem_rdata = '0;
   logic       acc_zero = 1'b0;
   logic [4:0] mem_addr;
   logic       mem_rd;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [2:0] opcode;
   logic [4:0] operand_addr;
   logic       instr_valid;
   logic       halted;
   logic [4:0] pc;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch #(
      .ADDR_W (5),
      .DATA_W (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .load_in      (load_in),
      .load_we      (load_we),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .mem_rdata    (mem_rdata),
      .acc_zero     (acc_zero),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .opcode       (opcode),
      .operand_addr (operand_addr),
      .instr_valid  (instr_valid),
      .halted       (halted),
      .pc           (pc)
   );

   always #5 clock = ~clock;

   // Memory model: synchronous write, one-cycle synchronous read.
   logic [7:0] tb_mem [32];
   initial for (int i = 0; i < 32; i++) tb_mem[i] = 8'h00;
   always @(posedge clock) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= tb_mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard of expected executed instructions.
   typedef struct packed {
      logic [2:0] op;
      logic [4:0] opnd;
      logic [4:0] pc;
   } exp_t;
   exp_t sb[$];
   logic prev_valid = 1'b0;

   task automatic push_instr(input logic [7:0] instr, input logic [4:0] at_pc);
      exp_t e;
      e.op   = instr[7:5];
      e.opnd = instr[4:0];
      e.pc   = at_pc;
      sb.push_back(e);
   endtask

   // Monitor: pops one expectation per instr_valid pulse, checks opcode gating otherwise.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (instr_valid) begin
            check("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_instr_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("exec_opcode", {29'd0, opcode}, {29'd0, e.op});
               check("exec_operand", {27'd0, operand_addr}, {27'd0, e.opnd});
               check("exec_pc", {27'd0, pc}, {27'd0, e.pc});
            end
         end else begin
            check("opcode_gated", {29'd0, opcode}, 32'd0);
         end
      end
      prev_valid = instr_valid;
   end

   task automatic load_word(input logic [4:0] a, input logic [7:0] d);
      @(negedge clock);
      load_in   = 1'b1;
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
   endtask

   task automatic start_run();
      @(negedge clock);
      load_we = 1'b0;
      load_in = 1'b0;
   endtask

   task automatic stop_run();
      load_in = 1'b1;
      @(negedge clock);
   endtask

   typedef struct {
      logic [7:0] instr;
      logic [4:0] start;
      logic       acc;
      logic [4:0] exp_pc;
      logic       exp_halt;
   } vec_t;
   vec_t vecs[9];

   initial begin
      vecs[0] = '{8'hA5, 5'd3,  1'b0, 5'd4,  1'b0};  // LDA: +1
      vecs[1] = '{8'h20, 5'd3,  1'b1, 5'd5,  1'b0};  // SKZ taken
      vecs[2] = '{8'h20, 5'd3,  1'b0, 5'd4,  1'b0};  // SKZ not taken
      vecs[3] = '{8'hFE, 5'd4,  1'b0, 5'd30, 1'b0};  // JMP 30
      vecs[4] = '{8'h20, 5'd30, 1'b1, 5'd0,  1'b0};  // SKZ wrap 30->0
      vecs[5] = '{8'h20, 5'd31, 1'b1, 5'd1,  1'b0};  // SKZ wrap 31->1
      vecs[6] = '{8'h41, 5'd31, 1'b0, 5'd0,  1'b0};  // ADD wrap 31->0
      vecs[7] = '{8'h20, 5'd31, 1'b0, 5'd0,  1'b0};  // SKZ not taken, wrap
      vecs[8] = '{8'h00, 5'd1,  1'b1, 5'd2,  1'b1};  // HLT

      // Reset values.
      @(negedge clock);
      #1;
      check("rst_pc", {27'd0, pc}, 32'd0);
      check("rst_opcode", {29'd0, opcode}, 32'd0);
      check("rst_operand", {27'd0, operand_addr}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);

      // Startup: first FETCH one cycle after release; empty memory executes HLT at 0.
      push_instr(8'h00, 5'd0);
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("startup_mem_rd", {31'd0, mem_rd}, 32'd1);
      check("startup_mem_addr", {27'd0, mem_addr}, 32'd0);
      repeat (4) @(posedge clock);
      @(negedge clock);
      #1;
      check("startup_halted", {31'd0, halted}, 32'd1);
      check("startup_pc", {27'd0, pc}, 32'd1);

      // Load and run: LDA 5, HLT.
      load_word(5'd0, 8'hA5);
      load_word(5'd1, 8'h00);
      push_instr(8'hA5, 5'd0);
      push_instr(8'h00, 5'd1);
      start_run();
      repeat (7) @(posedge clock);
      @(negedge clock);
      #1;
      check("lr_halted", {31'd0, halted}, 32'd1);
      check("lr_pc", {27'd0, pc}, 32'd2);
      check("lr_sb_drained", sb.size(), 32'd0);
      repeat (4) @(negedge clock);
      #1;
      check("lr_pc_frozen", {27'd0, pc}, 32'd2);
      check("lr_still_halted", {31'd0, halted}, 32'd1);

      // Vector table: JMP from 0 to start, then execute one instruction there.
      for (int i = 0; i < 9; i++) begin
         load_word(5'd0, {3'b111, vecs[i].start});
         load_word(vecs[i].start, vecs[i].instr);
         acc_zero = vecs[i].acc;
         push_instr({3'b111, vecs[i].start}, 5'd0);
         push_instr(vecs[i].instr, vecs[i].start);
         start_run();
         repeat (7) @(posedge clock);
         @(negedge clock);
         #1;
         check($sformatf("vec%0d_pc", i), {27'd0, pc}, {27'd0, vecs[i].exp_pc});
         check($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].exp_halt});
         check($sformatf("vec%0d_sb_drained", i), sb.size(), 32'd0);
         stop_run();
      end
      acc_zero = 1'b0;

      // Three sequential instructions then HLT.
      load_word(5'd0, 8'hA5);
      load_word(5'd1, 8'h41);
      load_word(5'd2, 8'hC7);
      load_word(5'd3, 8'h00);
      push_instr(8'hA5, 5'd0);
      push_instr(8'h41, 5'd1);
      push_instr(8'hC7, 5'd2);
      push_instr(8'h00, 5'd3);
      start_run();
      repeat (13) @(posedge clock);
      @(negedge clock);
      #1;
      check("seq_halted", {31'd0, halted}, 32'd1);
      check("seq_pc", {27'd0, pc}, 32'd4);
      check("seq_sb_drained", sb.size(), 32'd0);

      // Load override during EXEC of 8'h41.
      load_word(5'd0, 8'h41);
      push_instr(8'h41, 5'd0);
      start_run();
      repeat (3) @(posedge clock);
      @(negedge clock);
      load_in   = 1'b1;
      load_we   = 1'b1;
      load_addr = 5'd9;
      load_data = 8'h55;
      #1;
      check("ovr_mem_we", {31'd0, mem_we}, 32'd1);
      check("ovr_mem_addr", {27'd0, mem_addr}, 32'd9);
      check("ovr_mem_wdata", {24'd0, mem_wdata}, 32'h55);
      check("ovr_mem_rd", {31'd0, mem_rd}, 32'd0);
      @(negedge clock);
      #1;
      check("ovr_pc", {27'd0, pc}, 32'd0);
      check("ovr_opcode", {29'd0, opcode}, 32'd0);
      check("ovr_operand", {27'd0, operand_addr}, 32'd0);
      check("ovr_mem_written", {24'd0, tb_mem[9]}, 32'h55);
      load_we = 1'b0;
      #1;
      check("ovr_mem_we_low", {31'd0, mem_we}, 32'd0);
      check("ovr_sb_drained", sb.size(), 32'd0);

      // Reset in LATCH of the instruction at pc 5.
      load_word(5'd0, 8'hE5);
      load_word(5'd5, 8'hA3);
      push_instr(8'hE5, 5'd0);
      start_run();
      repeat (5) @(posedge clock);
      @(negedge clock);
      #1;
      check("mfr_pc_before", {27'd0, pc}, 32'd5);
      reset = 1'b1;
      #1;
      check("mfr_pc", {27'd0, pc}, 32'd0);
      check("mfr_operand", {27'd0, operand_addr}, 32'd0);
      check("mfr_opcode", {29'd0, opcode}, 32'd0);
      check("mfr_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("mfr_mem_addr", {27'd0, mem_addr}, 32'd0);
      check("mfr_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("mfr_refetch_rd", {31'd0, mem_rd}, 32'd1);
      check("mfr_refetch_addr", {27'd0, mem_addr}, 32'd0);
      check("mfr_sb_drained", sb.size(), 32'd0);
      stop_run();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
